// File: rtl/tt_gpio_pkg.sv
// Shared definitions for the GPIO pad-configuration stage: mode codes,
// FSM state encoding and the decoded per-pad control bundle.
package tt_gpio_pkg;

    localparam int MODE_W = 3;
    localparam int IDX_W  = 6;

    localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_IN     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_IN_PU  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_IN_PD  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_OUT    = 3'd4;
    localparam logic [MODE_W-1:0] MODE_BIDIR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_ANALOG = 3'd6;
    localparam logic [MODE_W-1:0] MODE_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One pad's worth of gpiov2 control bits
    typedef struct packed {
        logic [2:0] dm;
        logic       inp_dis;
        logic       analog_en;
        logic       out;
        logic       oeb;
    } pad_ctrl_t;

    // The reserved code must never reach a mode register
    function automatic logic mode_is_valid(input logic [MODE_W-1:0] mode);
        return mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/tt_gpio_mode_dec.sv
// Combinational decode of one pad mode into the sky130 gpiov2 control bits,
// muxing the core's out/oeb through only for the driving modes.
module tt_gpio_mode_dec
    import tt_gpio_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic              core_out,
    input  logic              core_oeb,
    output pad_ctrl_t         pad
);

    // Table decode; anything unexpected falls back to the safe OFF setting
    always_comb begin
        pad = '{dm: 3'b000, inp_dis: 1'b1, analog_en: 1'b0, out: 1'b0, oeb: 1'b1};
        case (mode)
            MODE_OFF:    pad = '{dm: 3'b000, inp_dis: 1'b1, analog_en: 1'b0, out: 1'b0,     oeb: 1'b1};
            MODE_IN:     pad = '{dm: 3'b001, inp_dis: 1'b0, analog_en: 1'b0, out: 1'b0,     oeb: 1'b1};
            MODE_IN_PU:  pad = '{dm: 3'b010, inp_dis: 1'b0, analog_en: 1'b0, out: 1'b1,     oeb: 1'b0};
            MODE_IN_PD:  pad = '{dm: 3'b011, inp_dis: 1'b0, analog_en: 1'b0, out: 1'b0,     oeb: 1'b0};
            MODE_OUT:    pad = '{dm: 3'b110, inp_dis: 1'b0, analog_en: 1'b0, out: core_out, oeb: 1'b0};
            MODE_BIDIR:  pad = '{dm: 3'b110, inp_dis: 1'b0, analog_en: 1'b0, out: core_out, oeb: core_oeb};
            MODE_ANALOG: pad = '{dm: 3'b000, inp_dis: 1'b1, analog_en: 1'b1, out: 1'b0,     oeb: 1'b1};
            default:     pad = '{dm: 3'b000, inp_dis: 1'b1, analog_en: 1'b0, out: 1'b0,     oeb: 1'b1};
        endcase
    end

endmodule

// File: rtl/tt_gpio_ctrl.sv
// Runtime pad-configuration stage: shadow/active mode banks per pad, a
// staggered apply sequencer, and per-pad decode onto the gpiov2 pad vectors.
module tt_gpio_ctrl
    import tt_gpio_pkg::*;
#(
    parameter int                N_PADS       = 44,
    parameter int                STAGGER      = 4,
    parameter logic [MODE_W-1:0] DEFAULT_MODE = MODE_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic              cfg_commit,
    output logic              cfg_err,
    output logic              busy,
    output logic              done,
    input  logic [N_PADS-1:0] core_out,
    input  logic [N_PADS-1:0] core_oeb,
    output logic [N_PADS-1:0] pad_out,
    output logic [N_PADS-1:0] pad_oeb,
    output logic [N_PADS-1:0] pad_inp_dis,
    output logic [N_PADS-1:0] pad_analog_en,
    output logic [N_PADS-1:0] pad_dm2,
    output logic [N_PADS-1:0] pad_dm1,
    output logic [N_PADS-1:0] pad_dm0
);

    // Wait counter only needs to hold STAGGER-2
    localparam int                CNT_W     = (STAGGER > 2) ? $clog2(STAGGER - 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'((STAGGER > 1) ? (STAGGER - 2) : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PADS - 1);
    localparam logic [IDX_W:0]    PAD_LIMIT = (IDX_W + 1)'(N_PADS);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              done_next;

    logic [MODE_W-1:0] shadow [N_PADS];
    logic [MODE_W-1:0] active [N_PADS];
    logic [MODE_W-1:0] cur_shadow;
    logic [MODE_W-1:0] cur_active;

    logic              addr_ok;
    logic              write_req;
    logic              write_bad;
    logic              write_en;
    logic              apply_en;
    logic              mode_changes;
    logic              last_pad;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    assign addr_ok   = ({1'b0, cfg_addr} < PAD_LIMIT);
    assign write_req = cfg_valid && cfg_ready;
    assign write_bad = write_req && !(addr_ok && mode_is_valid(cfg_mode));
    assign write_en  = write_req && !write_bad;

    assign apply_en     = (state == ST_APPLY);
    assign mode_changes = (cur_shadow != cur_active);
    assign last_pad     = (idx == LAST_IDX);

    // Select the shadow and active modes of the pad currently being applied
    always_comb begin
        cur_shadow = DEFAULT_MODE;
        cur_active = DEFAULT_MODE;
        for (int i = 0; i < N_PADS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_shadow = shadow[i];
                cur_active = active[i];
            end
        end
    end

    // Sequencer: walk every pad once, dwelling STAGGER cycles on pads that change
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_commit) begin
                    state_next = ST_APPLY;
                    idx_next   = '0;
                end
            end
            ST_APPLY: begin
                if (mode_changes && (STAGGER > 1)) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_INIT;
                end else if (last_pad) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next   = idx + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    if (last_pad) begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_APPLY;
                        idx_next   = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Sequencer state, pad index and dwell counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    // Registered status pulses for rejected writes and completed passes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            cfg_err <= write_bad;
            done    <= done_next;
        end
    end

    // Shadow bank takes accepted writes only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PADS; i++) begin
                shadow[i] <= DEFAULT_MODE;
            end
        end else if (write_en) begin
            for (int i = 0; i < N_PADS; i++) begin
                if (cfg_addr == IDX_W'(i)) begin
                    shadow[i] <= cfg_mode;
                end
            end
        end
    end

    // Active bank copies one pad from the shadow per APPLY cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PADS; i++) begin
                active[i] <= DEFAULT_MODE;
            end
        end else if (apply_en) begin
            for (int i = 0; i < N_PADS; i++) begin
                if (idx == IDX_W'(i)) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        pad_ctrl_t ctrl;

        tt_gpio_mode_dec u_dec (
            .mode     (active[p]),
            .core_out (core_out[p]),
            .core_oeb (core_oeb[p]),
            .pad      (ctrl)
        );

        assign pad_dm2[p]       = ctrl.dm[2];
        assign pad_dm1[p]       = ctrl.dm[1];
        assign pad_dm0[p]       = ctrl.dm[0];
        assign pad_inp_dis[p]   = ctrl.inp_dis;
        assign pad_analog_en[p] = ctrl.analog_en;
        assign pad_out[p]       = ctrl.out;
        assign pad_oeb[p]       = ctrl.oeb;
    end

endmodule

// File: tb/tb_tt_gpio_ctrl.sv
// Scoreboard bench for tt_gpio_ctrl: a mode model predicts pad vectors,
// pulse timing and pass lengths, compared as the DUT produces them.
module tb_tt_gpio_ctrl;

    localparam int N_PADS  = 44;
    localparam int STAGGER = 4;

    localparam int S_OUT        = 0;
    localparam int S_OEB        = 1;
    localparam int S_INP_DIS    = 2;
    localparam int S_ANALOG     = 3;
    localparam int S_DM2        = 4;
    localparam int S_DM1        = 5;
    localparam int S_DM0        = 6;
    localparam int S_BUSY       = 7;
    localparam int S_READY      = 8;
    localparam int S_ERR        = 9;
    localparam int S_DONE       = 10;
    localparam int S_PASS_LEN   = 11;
    localparam int S_DONE_END   = 12;
    localparam int S_DONE_AFTER = 13;
    localparam int S_MAX_SIMUL  = 14;
    localparam int S_TIMING_ERR = 15;
    localparam int S_DONE_COUNT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [5:0]        cfg_addr;
    logic [2:0]        cfg_mode;
    logic              cfg_commit;
    logic              cfg_err;
    logic              busy;
    logic              done;
    logic [N_PADS-1:0] core_out;
    logic [N_PADS-1:0] core_oeb;
    logic [N_PADS-1:0] pad_out;
    logic [N_PADS-1:0] pad_oeb;
    logic [N_PADS-1:0] pad_inp_dis;
    logic [N_PADS-1:0] pad_analog_en;
    logic [N_PADS-1:0] pad_dm2;
    logic [N_PADS-1:0] pad_dm1;
    logic [N_PADS-1:0] pad_dm0;

    int checks   = 0;
    int failures = 0;

    int model_shadow [N_PADS];
    int model_active [N_PADS];
    int first_change [N_PADS];
    logic [6:0] prev_vec [N_PADS];

    int obs_pass_len;
    int obs_done_end;
    int obs_done_after;
    int obs_max_simul;
    int obs_timing_err;
    int obs_done_count;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    tt_gpio_ctrl #(
        .N_PADS  (N_PADS),
        .STAGGER (STAGGER)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_mode      (cfg_mode),
        .cfg_commit    (cfg_commit),
        .cfg_err       (cfg_err),
        .busy          (busy),
        .done          (done),
        .core_out      (core_out),
        .core_oeb      (core_oeb),
        .pad_out       (pad_out),
        .pad_oeb       (pad_oeb),
        .pad_inp_dis   (pad_inp_dis),
        .pad_analog_en (pad_analog_en),
        .pad_dm2       (pad_dm2),
        .pad_dm1       (pad_dm1),
        .pad_dm0       (pad_dm0)
    );

    always #5 clk = ~clk;

    // Reference decode {dm2,dm1,dm0,inp_dis,analog_en,out,oeb}
    function automatic logic [6:0] refDecode(input int mode, input logic co, input logic coe);
        case (mode)
            0:       return 7'b000_1_0_0_1;
            1:       return 7'b001_0_0_0_1;
            2:       return 7'b010_0_0_1_0;
            3:       return 7'b011_0_0_0_0;
            4:       return {3'b110, 1'b0, 1'b0, co, 1'b0};
            5:       return {3'b110, 1'b0, 1'b0, co, coe};
            6:       return 7'b000_1_1_0_1;
            default: return 7'b000_1_0_0_1;
        endcase
    endfunction

    function automatic logic [63:0] expPads(input int sel);
        logic [63:0] v;
        logic [6:0]  d;
        v = '0;
        for (int i = 0; i < N_PADS; i++) begin
            d = refDecode(model_active[i], core_out[i], core_oeb[i]);
            case (sel)
                S_OUT:     v[i] = d[1];
                S_OEB:     v[i] = d[0];
                S_INP_DIS: v[i] = d[3];
                S_ANALOG:  v[i] = d[2];
                S_DM2:     v[i] = d[6];
                S_DM1:     v[i] = d[5];
                default:   v[i] = d[4];
            endcase
        end
        return v;
    endfunction

    function automatic logic [6:0] padVec(input int i);
        return {pad_dm2[i], pad_dm1[i], pad_dm0[i], pad_inp_dis[i],
                pad_analog_en[i], pad_out[i], pad_oeb[i]};
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_OUT:        return 64'(pad_out);
            S_OEB:        return 64'(pad_oeb);
            S_INP_DIS:    return 64'(pad_inp_dis);
            S_ANALOG:     return 64'(pad_analog_en);
            S_DM2:        return 64'(pad_dm2);
            S_DM1:        return 64'(pad_dm1);
            S_DM0:        return 64'(pad_dm0);
            S_BUSY:       return 64'(busy);
            S_READY:      return 64'(cfg_ready);
            S_ERR:        return 64'(cfg_err);
            S_DONE:       return 64'(done);
            S_PASS_LEN:   return 64'(obs_pass_len);
            S_DONE_END:   return 64'(obs_done_end);
            S_DONE_AFTER: return 64'(obs_done_after);
            S_MAX_SIMUL:  return 64'(obs_max_simul);
            S_TIMING_ERR: return 64'(obs_timing_err);
            default:      return 64'(obs_done_count);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input string tag, input int sel, input logic [63:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic expectPads(input string tag);
        for (int s = S_OUT; s <= S_DM0; s++) begin
            pushExpect($sformatf("%s_pads%0d", tag, s), s, expPads(s));
        end
    endtask

    task automatic drainScoreboard();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checkOutput(it.tag, observe(it.sel), it.exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < N_PADS; i++) begin
            model_shadow[i] = 1;
            model_active[i] = 1;
        end
    endfunction

    // One shadow write, checking the cfg_err pulse the cycle after
    task automatic applyStimulus(input int addr, input int mode);
        bit ok;
        ok = (addr < N_PADS) && (mode != 7);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_addr  = 6'(addr);
        cfg_mode  = 3'(mode);
        if (ok) model_shadow[addr] = mode;
        pushExpect($sformatf("cfg_err_a%0d_m%0d", addr, mode), S_ERR, ok ? 64'd0 : 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        drainScoreboard();
    endtask

    // Commit and observe a full apply pass
    task automatic commitPass(input string tag, input bit check_stagger);
        int changed;
        int k;
        int n;
        logic [6:0] cur;
        changed = 0;
        for (int i = 0; i < N_PADS; i++) begin
            if (model_shadow[i] != model_active[i]) changed++;
        end
        pushExpect({tag, "_pass_len"}, S_PASS_LEN, 64'(N_PADS + changed * (STAGGER - 1)));
        pushExpect({tag, "_done_end"}, S_DONE_END, 64'd1);
        pushExpect({tag, "_done_after"}, S_DONE_AFTER, 64'd0);
        if (check_stagger) begin
            pushExpect({tag, "_max_simul"}, S_MAX_SIMUL, 64'd1);
            pushExpect({tag, "_timing_err"}, S_TIMING_ERR, 64'd0);
        end
        for (int i = 0; i < N_PADS; i++) begin
            prev_vec[i]     = padVec(i);
            first_change[i] = -1;
        end
        obs_pass_len  = 0;
        obs_max_simul = 0;
        obs_done_end  = 0;
        @(posedge clk); #1;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            n = 0;
            for (int i = 0; i < N_PADS; i++) begin
                cur = padVec(i);
                if (cur !== prev_vec[i]) begin
                    n++;
                    if (first_change[i] < 0) first_change[i] = k;
                    prev_vec[i] = cur;
                end
            end
            if (n > obs_max_simul) obs_max_simul = n;
            if (busy) begin
                obs_pass_len++;
            end else begin
                obs_done_end = int'(done);
                break;
            end
        end
        @(negedge clk);
        obs_done_after = int'(done);
        obs_timing_err = 0;
        for (int i = 0; i < N_PADS; i++) begin
            if (first_change[i] != 2 + STAGGER * i) obs_timing_err++;
        end
        for (int i = 0; i < N_PADS; i++) model_active[i] = model_shadow[i];
        expectPads(tag);
        drainScoreboard();
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_mode   = '0;
        cfg_commit = 1'b0;
        core_out   = '0;
        core_oeb   = '1;
        modelReset();

        // Reset defaults
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expectPads("reset");
        pushExpect("reset_busy", S_BUSY, 64'd0);
        pushExpect("reset_ready", S_READY, 64'd1);
        pushExpect("reset_err", S_ERR, 64'd0);
        pushExpect("reset_done", S_DONE, 64'd0);
        drainScoreboard();

        // Single change: pad 5 to OUT
        core_out    = N_PADS'({$urandom, $urandom});
        core_out[5] = 1'b1;
        core_oeb    = N_PADS'({$urandom, $urandom});
        applyStimulus(5, 4);
        commitPass("single", 1'b0);
        core_out[5] = 1'b0;
        #1;
        expectPads("single_track0");
        drainScoreboard();
        core_out = ~core_out;
        core_oeb = ~core_oeb;
        #1;
        expectPads("single_track1");
        drainScoreboard();

        // Rejected writes leave the shadow alone; boundary addresses 43/44
        applyStimulus(50, 4);
        applyStimulus(3, 7);
        applyStimulus(44, 2);
        applyStimulus(43, 1);
        commitPass("reject", 1'b0);

        // Pull modes ignore the core
        applyStimulus(10, 2);
        applyStimulus(11, 3);
        core_out = '0;
        core_oeb = '1;
        commitPass("pulls", 1'b0);
        core_out = '1;
        #1;
        expectPads("pulls_out1");
        drainScoreboard();
        core_oeb = '0;
        #1;
        expectPads("pulls_oeb0");
        drainScoreboard();

        // Full stagger: every pad to BIDIR
        core_oeb = '1;
        core_out = N_PADS'({$urandom, $urandom});
        for (int i = 0; i < N_PADS; i++) applyStimulus(i, 5);
        commitPass("stagger", 1'b1);
        core_oeb = N_PADS'({$urandom, $urandom});
        #1;
        expectPads("stagger_oeb");
        drainScoreboard();

        // Reset in the middle of a pass, with a write held while busy
        for (int i = 0; i < N_PADS; i++) applyStimulus(i, i % 5);
        @(posedge clk); #1;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                cfg_valid = 1'b1;
                cfg_addr  = 6'd0;
                cfg_mode  = 3'd7;
            end
            if (k == 6 || k == 7) begin
                pushExpect($sformatf("busy_ready_k%0d", k), S_READY, 64'd0);
                pushExpect($sformatf("busy_err_k%0d", k), S_ERR, 64'd0);
                pushExpect($sformatf("busy_busy_k%0d", k), S_BUSY, 64'd1);
                drainScoreboard();
            end
            if (k == 8) cfg_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        expectPads("midreset");
        pushExpect("midreset_busy", S_BUSY, 64'd0);
        pushExpect("midreset_ready", S_READY, 64'd1);
        pushExpect("midreset_done", S_DONE, 64'd0);
        drainScoreboard();
        obs_done_count = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) obs_done_count++;
        end
        pushExpect("midreset_no_done", S_DONE_COUNT, 64'd0);
        drainScoreboard();
        commitPass("post_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
